// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: widths, ALU opcodes and
// the record describing what the stage holds.
package id_ex_stage_pkg;

  localparam int unsigned REG_AW = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned BUBBLE_CNT_W = 16;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLL  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_SRA  = 4'h8,
    ALU_LUI  = 4'h9
  } alu_op_e;

  typedef struct packed {
    logic               valid;
    logic               regwrt;
    logic               memrd;
    logic               memwrt;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  rsval;
    logic [DATA_W-1:0]  rtval;
  } stage_t;

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Selects one source operand: EX/MEM result first, then the writeback bus,
// otherwise the register-file read value. Register 0 is an ordinary register.
module operand_forward
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_AW = id_ex_stage_pkg::REG_AW,
  parameter int unsigned DATA_W = id_ex_stage_pkg::DATA_W
) (
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] rf_val_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_regwrt_i,
  input  logic [DATA_W-1:0] exmem_val_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrt_i,
  input  logic [DATA_W-1:0] wb_val_i,
  output logic [DATA_W-1:0] val_o
);

  always_comb begin
    val_o = rf_val_i;
    if (exmem_regwrt_i && (exmem_rd_i == idx_i)) begin
      val_o = exmem_val_i;
    end else if (wb_regwrt_i && (wb_rd_i == idx_i)) begin
      val_o = wb_val_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard detection,
// bubble insertion and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_AW = id_ex_stage_pkg::REG_AW,
  parameter int unsigned DATA_W = id_ex_stage_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              in_rst,
  input  logic              in_valid,
  input  logic              in_stall,
  input  logic              in_flush,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rsval,
  input  logic [DATA_W-1:0] in_rtval,
  input  logic              in_ctrl_regwrt,
  input  logic              in_ctrl_memrd,
  input  logic              in_ctrl_memwrt,
  input  logic [3:0]        in_ctrl_aluop,
  input  logic [REG_AW-1:0] in_exmem_rd,
  input  logic              in_exmem_regwrt,
  input  logic [DATA_W-1:0] in_exmem_val,
  input  logic [REG_AW-1:0] in_wb_rd,
  input  logic              in_wb_regwrt,
  input  logic [DATA_W-1:0] in_wb_val,
  output logic              out_valid,
  output logic              out_ctrl_regwrt,
  output logic              out_ctrl_memrd,
  output logic              out_ctrl_memwrt,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_rsval,
  output logic [DATA_W-1:0] out_rtval,
  output logic [3:0]        out_ctrl_aluop,
  output logic              out_hazard,
  output logic [15:0]       out_bubble_cnt
);

  stage_t                  stage_q, stage_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [DATA_W-1:0]       rs_fwd, rt_fwd;
  logic                    hazard;

  operand_forward #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_fwd_rs (
    .idx_i          (in_rs),
    .rf_val_i       (in_rsval),
    .exmem_rd_i     (in_exmem_rd),
    .exmem_regwrt_i (in_exmem_regwrt),
    .exmem_val_i    (in_exmem_val),
    .wb_rd_i        (in_wb_rd),
    .wb_regwrt_i    (in_wb_regwrt),
    .wb_val_i       (in_wb_val),
    .val_o          (rs_fwd)
  );

  operand_forward #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_fwd_rt (
    .idx_i          (in_rt),
    .rf_val_i       (in_rtval),
    .exmem_rd_i     (in_exmem_rd),
    .exmem_regwrt_i (in_exmem_regwrt),
    .exmem_val_i    (in_exmem_val),
    .wb_rd_i        (in_wb_rd),
    .wb_regwrt_i    (in_wb_regwrt),
    .wb_val_i       (in_wb_val),
    .val_o          (rt_fwd)
  );

  // A load in this stage whose destination is read by the decode-slot instruction.
  assign hazard = stage_q.valid && stage_q.memrd && stage_q.regwrt && in_valid &&
                  ((stage_q.rd == in_rs) || (stage_q.rd == in_rt));

  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (in_flush) begin
      stage_d.valid  = 1'b0;
      stage_d.regwrt = 1'b0;
      stage_d.memrd  = 1'b0;
      stage_d.memwrt = 1'b0;
      stage_d.aluop  = '0;
    end else if (in_stall) begin
      // A held instruction must still see writebacks that land while it waits.
      if (stage_q.valid && in_wb_regwrt) begin
        if (in_wb_rd == stage_q.rs) stage_d.rsval = in_wb_val;
        if (in_wb_rd == stage_q.rt) stage_d.rtval = in_wb_val;
      end
    end else if (hazard) begin
      stage_d.valid  = 1'b0;
      stage_d.regwrt = 1'b0;
      stage_d.memrd  = 1'b0;
      stage_d.memwrt = 1'b0;
      stage_d.aluop  = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else begin
      stage_d.valid  = in_valid;
      stage_d.regwrt = in_valid & in_ctrl_regwrt;
      stage_d.memrd  = in_valid & in_ctrl_memrd;
      stage_d.memwrt = in_valid & in_ctrl_memwrt;
      stage_d.aluop  = in_valid ? in_ctrl_aluop : '0;
      stage_d.rs     = in_rs;
      stage_d.rt     = in_rt;
      stage_d.rd     = in_rd;
      stage_d.rsval  = rs_fwd;
      stage_d.rtval  = rt_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid       = stage_q.valid;
  assign out_ctrl_regwrt = stage_q.regwrt;
  assign out_ctrl_memrd  = stage_q.memrd;
  assign out_ctrl_memwrt = stage_q.memwrt;
  assign out_ctrl_aluop  = stage_q.aluop;
  assign out_rs          = stage_q.rs;
  assign out_rt          = stage_q.rt;
  assign out_rd          = stage_q.rd;
  assign out_rsval       = stage_q.rsval;
  assign out_rtval       = stage_q.rtval;
  assign out_hazard      = hazard;
  assign out_bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use bubbles, stall
// writeback capture, flush, counter saturation and reset.
module tb_id_ex_stage;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          in_rst, in_valid, in_stall, in_flush;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic [DW-1:0] in_rsval, in_rtval;
  logic          in_ctrl_regwrt, in_ctrl_memrd, in_ctrl_memwrt;
  logic [3:0]    in_ctrl_aluop;
  logic [AW-1:0] in_exmem_rd, in_wb_rd;
  logic          in_exmem_regwrt, in_wb_regwrt;
  logic [DW-1:0] in_exmem_val, in_wb_val;
  logic          out_valid, out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt;
  logic [AW-1:0] out_rs, out_rt, out_rd;
  logic [DW-1:0] out_rsval, out_rtval;
  logic [3:0]    out_ctrl_aluop;
  logic          out_hazard;
  logic [15:0]   out_bubble_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;

  id_ex_stage #(.REG_AW(AW), .DATA_W(DW)) dut (
    .clk(clk), .in_rst(in_rst), .in_valid(in_valid), .in_stall(in_stall),
    .in_flush(in_flush), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rsval(in_rsval), .in_rtval(in_rtval), .in_ctrl_regwrt(in_ctrl_regwrt),
    .in_ctrl_memrd(in_ctrl_memrd), .in_ctrl_memwrt(in_ctrl_memwrt),
    .in_ctrl_aluop(in_ctrl_aluop), .in_exmem_rd(in_exmem_rd),
    .in_exmem_regwrt(in_exmem_regwrt), .in_exmem_val(in_exmem_val),
    .in_wb_rd(in_wb_rd), .in_wb_regwrt(in_wb_regwrt), .in_wb_val(in_wb_val),
    .out_valid(out_valid), .out_ctrl_regwrt(out_ctrl_regwrt),
    .out_ctrl_memrd(out_ctrl_memrd), .out_ctrl_memwrt(out_ctrl_memwrt),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_rsval(out_rsval),
    .out_rtval(out_rtval), .out_ctrl_aluop(out_ctrl_aluop),
    .out_hazard(out_hazard), .out_bubble_cnt(out_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic [AW-1:0] rd, input logic [DW-1:0] rsv,
                           input logic [DW-1:0] rtv, input logic rw, input logic mr,
                           input logic mw, input logic [3:0] op);
    in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rsval = rsv; in_rtval = rtv;
    in_ctrl_regwrt = rw; in_ctrl_memrd = mr; in_ctrl_memwrt = mw; in_ctrl_aluop = op;
  endtask

  task automatic no_fwd();
    in_exmem_regwrt = 1'b0; in_exmem_rd = '0; in_exmem_val = '0;
    in_wb_regwrt = 1'b0; in_wb_rd = '0; in_wb_val = '0;
  endtask

  // lw r4 <- mem[r1]
  task automatic set_lw();
    set_instr(1'b1, 6'd1, 6'd2, 6'd4, 32'h11, 32'h22, 1'b1, 1'b1, 1'b0, 4'h0);
  endtask

  // add r6 <- r4 + r5 (depends on the load)
  task automatic set_add();
    set_instr(1'b1, 6'd4, 6'd5, 6'd6, 32'h44, 32'h55, 1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    in_rst = 1'b1; in_stall = 1'b0; in_flush = 1'b0;
    set_instr(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 4'h0);
    no_fwd();
    tick(); tick();
    chk("rst_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_ctrl",   {28'd0, out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt, 1'b0}, 32'd0);
    chk("rst_rsval",  out_rsval, 32'd0);
    chk("rst_cnt",    {16'd0, out_bubble_cnt}, 32'd0);
    chk("rst_hazard", {31'd0, out_hazard}, 32'd0);

    // EX/MEM wins over writeback for the same register
    in_rst = 1'b0;
    set_instr(1'b1, 6'd3, 6'd9, 6'd10, 32'h5, 32'h77, 1'b1, 1'b0, 1'b0, 4'h2);
    in_exmem_regwrt = 1'b1; in_exmem_rd = 6'd3; in_exmem_val = 32'hAA;
    in_wb_regwrt = 1'b1; in_wb_rd = 6'd3; in_wb_val = 32'hBB;
    tick();
    chk("fwd_exmem_rsval", out_rsval, 32'hAA);
    chk("fwd_rf_rtval", out_rtval, 32'h77);
    chk("load_valid", {31'd0, out_valid}, 32'd1);
    chk("load_rd", {26'd0, out_rd}, 32'd10);
    chk("load_aluop", {28'd0, out_ctrl_aluop}, 32'h2);

    // register 0 forwards like any other; rt from EX/MEM, rs from writeback
    set_instr(1'b1, 6'd0, 6'd3, 6'd12, 32'h5, 32'h77, 1'b1, 1'b0, 1'b1, 4'h1);
    in_exmem_regwrt = 1'b1; in_exmem_rd = 6'd3; in_exmem_val = 32'hCC;
    in_wb_regwrt = 1'b1; in_wb_rd = 6'd0; in_wb_val = 32'hBB;
    tick();
    chk("fwd_wb_r0_rsval", out_rsval, 32'hBB);
    chk("fwd_exmem_rtval", out_rtval, 32'hCC);
    chk("load_memwrt", {31'd0, out_ctrl_memwrt}, 32'd1);

    // invalid slot loads with all controls cleared
    no_fwd();
    set_instr(1'b0, 6'd7, 6'd8, 6'd9, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 4'h5);
    tick();
    chk("inv_valid", {31'd0, out_valid}, 32'd0);
    chk("inv_ctrl", {28'd0, out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt, 1'b0}, 32'd0);
    chk("inv_aluop", {28'd0, out_ctrl_aluop}, 32'd0);

    // load-use hazard
    set_lw();
    tick();
    set_add();
    in_valid = 1'b0; #1;
    chk("haz_needs_in_valid", {31'd0, out_hazard}, 32'd0);
    in_valid = 1'b1; #1;
    chk("haz_comb", {31'd0, out_hazard}, 32'd1);
    in_stall = 1'b1; #1;
    chk("haz_ignores_stall", {31'd0, out_hazard}, 32'd1);
    in_stall = 1'b0;
    tick();
    chk("bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble_memrd", {31'd0, out_ctrl_memrd}, 32'd0);
    chk("bubble_cnt1", {16'd0, out_bubble_cnt}, 32'd1);
    chk("bubble_no_haz", {31'd0, out_hazard}, 32'd0);
    tick();
    chk("after_bubble_valid", {31'd0, out_valid}, 32'd1);
    chk("after_bubble_rs", {26'd0, out_rs}, 32'd4);

    // three-cycle stall with writeback to the held rt in the second cycle
    set_instr(1'b1, 6'd6, 6'd7, 6'd8, 32'h66, 32'h55, 1'b1, 1'b0, 1'b0, 4'h3);
    tick();
    in_stall = 1'b1;
    set_instr(1'b1, 6'd1, 6'd2, 6'd3, 32'h98, 32'h99, 1'b1, 1'b1, 1'b1, 4'h9);
    tick();
    in_wb_regwrt = 1'b1; in_wb_rd = 6'd7; in_wb_val = 32'h12;
    tick();
    no_fwd();
    tick();
    chk("stall_wb_rtval", out_rtval, 32'h12);
    chk("stall_rsval", out_rsval, 32'h66);
    chk("stall_rt", {26'd0, out_rt}, 32'd7);
    chk("stall_rd", {26'd0, out_rd}, 32'd8);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_aluop", {28'd0, out_ctrl_aluop}, 32'h3);
    chk("stall_memwrt", {31'd0, out_ctrl_memwrt}, 32'd0);

    // flush beats stall
    in_flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_regwrt", {31'd0, out_ctrl_regwrt}, 32'd0);
    chk("flush_cnt", {16'd0, out_bubble_cnt}, 32'd1);
    in_flush = 1'b0; in_stall = 1'b0;

    // flush beats hazard: no bubble counted
    set_lw();
    tick();
    set_add();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    chk("flush_haz_cnt", {16'd0, out_bubble_cnt}, 32'd1);
    chk("flush_haz_valid", {31'd0, out_valid}, 32'd0);

    // saturation: preload the counter near the top, then keep inserting bubbles
    set_lw();
    tick();
    force dut.bubble_cnt_q = 16'hFFFD;
    #1;
    release dut.bubble_cnt_q;
    set_add();
    tick();
    chk("sat_fffe", {16'd0, out_bubble_cnt}, 32'hFFFE);
    set_lw(); tick();
    set_add(); tick();
    chk("sat_ffff", {16'd0, out_bubble_cnt}, 32'hFFFF);
    set_lw(); tick();
    set_add(); tick();
    chk("sat_hold", {16'd0, out_bubble_cnt}, 32'hFFFF);

    // reset while stalled on a hazard discards everything
    set_lw(); tick();
    set_add();
    in_stall = 1'b1;
    tick();
    chk("pre_rst_haz", {31'd0, out_hazard}, 32'd1);
    in_rst = 1'b1;
    tick();
    chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_ctrl", {28'd0, out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt, 1'b0}, 32'd0);
    chk("rst_stall_rd", {26'd0, out_rd}, 32'd0);
    chk("rst_stall_rsval", out_rsval, 32'd0);
    chk("rst_stall_cnt", {16'd0, out_bubble_cnt}, 32'd0);
    chk("rst_stall_haz", {31'd0, out_hazard}, 32'd0);
    in_rst = 1'b0; in_stall = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
